// File: rtl/fp_addsub_stream_pkg.sv
// Shared definitions for the FP add/sub accelerator: register offsets,
// STATUS/CTRL bit positions, mode and bus FSM encodings, STATUS packing.
// Ports: none (package).
package fp_addsub_stream_pkg;

  // Register offsets within the decoded window
  localparam logic [7:0] OFF_OPA    = 8'h00;
  localparam logic [7:0] OFF_OPB    = 8'h04;
  localparam logic [7:0] OFF_RESULT = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_CTRL   = 8'h10;

  // STATUS bit positions
  localparam int STS_NONEMPTY = 0;
  localparam int STS_FULL     = 1;
  localparam int STS_BUSY     = 2;
  localparam int STS_ERR      = 3;
  localparam int STS_CNT_LSB  = 8;
  localparam int STS_INF_LSB  = 16;
  localparam int STS_FIELD_W  = 5;

  // CTRL bit positions
  localparam int CTRL_MODE  = 0;
  localparam int CTRL_CLEAR = 1;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESP,
    S_STALL_ISSUE,
    S_STALL_READ,
    S_STALL_CLEAR
  } state_e;

  function automatic logic [31:0] pack_status(
    input logic                   nonempty,
    input logic                   full,
    input logic                   busy,
    input logic                   err,
    input logic [STS_FIELD_W-1:0] cnt,
    input logic [STS_FIELD_W-1:0] inf
  );
    logic [31:0] s;
    s = '0;
    s[STS_NONEMPTY] = nonempty;
    s[STS_FULL]     = full;
    s[STS_BUSY]     = busy;
    s[STS_ERR]      = err;
    s[STS_CNT_LSB +: STS_FIELD_W] = cnt;
    s[STS_INF_LSB +: STS_FIELD_W] = inf;
    return s;
  endfunction

endpackage

// File: rtl/fp_addsub_stream_if.sv
// Device-bus request/response bundle for the FP add/sub accelerator.
// Ports: en_i/we_i/addr_i/data_i driven by the master; ready_o/data_o by the slave.
// Master holds a request until ready_o; ready_o is a one-cycle completion pulse.
interface fp_addsub_stream_if #(
  parameter int XLEN = 32
);
  logic            en_i;
  logic            we_i;
  logic [XLEN-1:0] addr_i;
  logic [XLEN-1:0] data_i;
  logic            ready_o;
  logic [XLEN-1:0] data_o;

  modport master (output en_i, we_i, addr_i, data_i, input ready_o, data_o);
  modport slave  (input en_i, we_i, addr_i, data_i, output ready_o, data_o);
endinterface

// File: rtl/FP_ADDSUB.sv
// Behavioural stand-in for the single-precision adder IP (RNE, denormals flushed to zero).
// Latency: LATENCY cycles from s_axis valid to m_axis valid, fully pipelined.
// Backpressure: none; a result appears whether or not anyone is ready for it.
// Ports: aclk, aresetn, s_axis_a/b (tvalid, tdata), m_axis_result (tvalid, tdata).
module FP_ADDSUB #(
  parameter int LATENCY = 11
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_a_tvalid,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [31:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  output logic [31:0] m_axis_result_tdata
);

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [26:0] mx, my, mb, mask;
    logic [27:0] s;
    logic [24:0] m;
    logic        rnd;
    int          d, e;
    // x is the operand of larger magnitude, so the difference never goes negative
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    if (x[30:23] == 8'hFF) return x;
    if (x[30:23] == 8'h00) return 32'h0;
    if (y[30:23] == 8'h00) return x;
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    d  = int'(x[30:23]) - int'(y[30:23]);
    if (d > 26) begin
      mb = 27'd1;
    end else begin
      mask = (27'd1 << d) - 27'd1;
      mb   = (my >> d) | {26'd0, |(my & mask)};
    end
    if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, mb};
    else                s = {1'b0, mx} - {1'b0, mb};
    if (s == 28'd0) return 32'h0;
    e = int'(x[30:23]);
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!s[26]) begin
          s = s << 1;
          e = e - 1;
        end
      end
    end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    m   = {1'b0, s[26:3]} + {24'd0, rnd};
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    if (e <= 0)   return {x[31], 31'd0};
    return {x[31], e[7:0], m[22:0]};
  endfunction

  logic [31:0]        r_dat [LATENCY];
  logic [LATENCY-1:0] r_vld;

  always_ff @(posedge aclk) begin
    if (!aresetn) r_vld <= '0;
    else          r_vld <= {r_vld[LATENCY-2:0], s_axis_a_tvalid & s_axis_b_tvalid};
  end

  always_ff @(posedge aclk) begin
    r_dat[0] <= fp_add(s_axis_a_tdata, s_axis_b_tdata);
    for (int i = 1; i < LATENCY; i++) r_dat[i] <= r_dat[i-1];
  end

  assign m_axis_result_tvalid = r_vld[LATENCY-1];
  assign m_axis_result_tdata  = r_dat[LATENCY-1];

endmodule

// File: rtl/fp_result_fifo.sv
// Synchronous result FIFO with flush; push and pop together are allowed even when full.
// Latency: pushed data visible at the head the cycle after the push edge.
// Backpressure: push is dropped when full without a pop; pop is ignored when empty.
// Ports: i_clk, i_rst, i_push/i_push_dat, i_pop, i_flush, o_head_dat, o_full, o_empty, o_count.
module fp_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  assign w_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/fp_addsub_stream.sv
// Memory-mapped FP32 add/sub accelerator: OPA/OPB writes issue to a pipelined core, results queue for RESULT reads.
// Latency: ready_o one cycle after an unstalled request; OPB accept to STATUS nonempty is CORE_LAT+2 cycles.
// Backpressure: OPB stalls without a result credit, RESULT stalls while a result is in flight, clear stalls until drained.
// Ports: clk_i, rst_i (sync, active-high), bus (slave side of fp_addsub_stream_if).
module fp_addsub_stream
  import fp_addsub_stream_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'hC400_0000,
  parameter int              RES_DEPTH = 4,
  parameter int              CORE_LAT  = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fp_addsub_stream_if.slave bus
);
  localparam int CW = $clog2(RES_DEPTH) + 1;

  state_e            r_state, w_state_nxt;
  logic              r_ready;
  logic [XLEN-1:0]   r_data;
  mode_e             r_mode;
  logic [XLEN-1:0]   r_a;
  logic              r_a_loaded;
  logic              r_err;
  logic [4:0]        r_inflight;
  logic              r_issue_vld;
  logic [XLEN-1:0]   r_issue_a;
  logic [XLEN-1:0]   r_issue_b;

  logic              w_resp, w_issue, w_pop, w_clear, w_set_err, w_load_a, w_mode_wr;
  logic [XLEN-1:0]   w_rdata;
  logic              w_in_win;
  logic [7:0]        w_off;
  logic              w_credit;
  logic              w_core_vld, w_core_done;
  logic [31:0]       w_core_dat;
  logic [XLEN-1:0]   w_head;
  logic              w_full, w_empty;
  logic [CW-1:0]     w_fifo_count;
  logic [XLEN-1:0]   w_status;

  assign w_in_win = (bus.addr_i[XLEN-1:8] == BASE_ADDR[XLEN-1:8]);
  assign w_off    = bus.addr_i[7:0];
  // Every in-flight op already owns a FIFO slot, so the FIFO can never overflow.
  assign w_credit = (6'(r_inflight) + 6'(w_fifo_count)) < 6'(RES_DEPTH);
  // Results landing after a reset find in_flight=0 and are dropped.
  assign w_core_done = w_core_vld && (r_inflight != '0);
  assign w_status = pack_status(!w_empty, w_full, r_inflight != '0, r_err,
                                5'(w_fifo_count), r_inflight);

  // Stall states re-decode the live request each cycle; the master holds it stable.
  // A master that drops en_i while stalled withdraws the request.
  always_comb begin
    w_state_nxt = r_state;
    w_resp      = 1'b0;
    w_rdata     = '0;
    w_issue     = 1'b0;
    w_pop       = 1'b0;
    w_clear     = 1'b0;
    w_set_err   = 1'b0;
    w_load_a    = 1'b0;
    w_mode_wr   = 1'b0;
    if (r_state == S_RESP) begin
      w_state_nxt = S_IDLE;
    end else if (!bus.en_i) begin
      w_state_nxt = S_IDLE;
    end else if (!w_in_win) begin
      w_resp = 1'b1;
    end else begin
      unique case (w_off)
        OFF_OPA: begin
          w_load_a = bus.we_i;
          w_resp   = 1'b1;
        end
        OFF_OPB: begin
          if (!bus.we_i) begin
            w_resp = 1'b1;
          end else if (!r_a_loaded) begin
            w_set_err = 1'b1;
            w_resp    = 1'b1;
          end else if (w_credit) begin
            w_issue = 1'b1;
            w_resp  = 1'b1;
          end else begin
            w_state_nxt = S_STALL_ISSUE;
          end
        end
        OFF_RESULT: begin
          if (bus.we_i) begin
            w_resp = 1'b1;
          end else if (!w_empty) begin
            w_pop   = 1'b1;
            w_rdata = w_head;
            w_resp  = 1'b1;
          end else if (r_inflight != '0) begin
            w_state_nxt = S_STALL_READ;
          end else begin
            w_set_err = 1'b1;
            w_resp    = 1'b1;
          end
        end
        OFF_STATUS: begin
          if (!bus.we_i) w_rdata = w_status;
          w_resp = 1'b1;
        end
        OFF_CTRL: begin
          if (!bus.we_i) begin
            w_rdata[CTRL_MODE] = r_mode;
            w_resp             = 1'b1;
          end else if (!bus.data_i[CTRL_CLEAR]) begin
            w_mode_wr = 1'b1;
            w_resp    = 1'b1;
          end else if (r_inflight == '0) begin
            w_clear   = 1'b1;
            w_mode_wr = 1'b1;
            w_resp    = 1'b1;
          end else begin
            w_state_nxt = S_STALL_CLEAR;
          end
        end
        default: w_resp = 1'b1;
      endcase
      if (w_resp) w_state_nxt = S_RESP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_data      <= '0;
      r_mode      <= MODE_ADD;
      r_a         <= '0;
      r_a_loaded  <= 1'b0;
      r_err       <= 1'b0;
      r_inflight  <= '0;
      r_issue_vld <= 1'b0;
      r_issue_a   <= '0;
      r_issue_b   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= w_resp;
      r_data      <= w_resp ? w_rdata : '0;
      r_issue_vld <= w_issue;
      if (w_issue) begin
        r_issue_a <= r_a;
        // Subtract is an add with B's sign flipped
        r_issue_b <= {bus.data_i[XLEN-1] ^ (r_mode == MODE_SUB), bus.data_i[XLEN-2:0]};
      end
      if (w_load_a) begin
        r_a        <= bus.data_i;
        r_a_loaded <= 1'b1;
      end
      if (w_mode_wr) r_mode <= mode_e'(bus.data_i[CTRL_MODE]);
      if (w_clear) begin
        r_err      <= 1'b0;
        r_a_loaded <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
      unique case ({w_issue, w_core_done})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign bus.ready_o = r_ready;
  assign bus.data_o  = r_data;

  FP_ADDSUB #(
    .LATENCY (CORE_LAT)
  ) u_core (
    .aclk                 (clk_i),
    .aresetn              (!rst_i),
    .s_axis_a_tvalid      (r_issue_vld),
    .s_axis_a_tdata       (r_issue_a),
    .s_axis_b_tvalid      (r_issue_vld),
    .s_axis_b_tdata       (r_issue_b),
    .m_axis_result_tvalid (w_core_vld),
    .m_axis_result_tdata  (w_core_dat)
  );

  fp_result_fifo #(
    .WIDTH (XLEN),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_push     (w_core_done),
    .i_push_dat (w_core_dat),
    .i_pop      (w_pop),
    .i_flush    (w_clear),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_fifo_count)
  );

endmodule

// File: tb/tb_fp_addsub_stream.sv
// Directed bench for fp_addsub_stream: add/sub results, credit stall, blocking and empty reads,
// clear, reset mid-flight, error and unmapped accesses.
// Ports: none (top-level bench).
module tb_fp_addsub_stream;
  localparam int          CORE_LAT = 11;
  localparam logic [31:0] BASE     = 32'hC400_0000;
  localparam logic [7:0]  A_OPA = 8'h00, A_OPB = 8'h04, A_RES = 8'h08, A_STS = 8'h0C, A_CTRL = 8'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  fp_addsub_stream_if #(.XLEN(32)) bus ();

  fp_addsub_stream #(
    .XLEN      (32),
    .BASE_ADDR (BASE),
    .RES_DEPTH (4),
    .CORE_LAT  (CORE_LAT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that raised ready_o.
  task automatic xfer(input logic we, input logic [7:0] off, input logic [31:0] wd, input int max_cyc,
                      output logic [31:0] rdat, output logic got, output int ncyc);
    bus.en_i = 1'b1; bus.we_i = we; bus.addr_i = BASE | {24'd0, off}; bus.data_i = wd;
    got = 1'b0; ncyc = 0; rdat = 32'hDEAD_BEEF;
    while (!got && ncyc < max_cyc) begin
      @(posedge clk); #1;
      ncyc++;
      if (bus.ready_o) begin got = 1'b1; rdat = bus.data_o; end
    end
    bus.en_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wd, output logic got, output int ncyc);
    logic [31:0] dummy;
    xfer(1'b1, off, wd, 40, dummy, got, ncyc);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] rdat, output int ncyc);
    logic got;
    xfer(1'b0, off, 32'h0, 40, rdat, got, ncyc);
  endtask

  task automatic test_reset();
    logic [31:0] v; int c;
    n_total++; if (bus.ready_o !== 1'b0) $display("FAIL reset_ready got=%b exp=0", bus.ready_o); else n_pass++;
    n_total++; if (bus.data_o !== 32'h0) $display("FAIL reset_data got=%h exp=0", bus.data_o); else n_pass++;
    rd(A_STS, v, c);
    n_total++; if (v !== 32'h0) $display("FAIL reset_status got=%h exp=%h", v, 32'h0); else n_pass++;
    rd(A_CTRL, v, c);
    n_total++; if (v !== 32'h0) $display("FAIL reset_mode got=%h exp=%h", v, 32'h0); else n_pass++;
  endtask

  task automatic test_err_unmapped();
    logic [31:0] v; int c; logic g;
    wr(A_OPB, 32'h3F80_0000, g, c);
    n_total++; if (g !== 1'b1) $display("FAIL opb_noa_ready got=%b exp=1", g); else n_pass++;
    rd(A_STS, v, c);
    n_total++; if (v !== 32'h8) $display("FAIL opb_noa_status got=%h exp=%h", v, 32'h8); else n_pass++;
    idle(1);
    rd(8'h20, v, c);
    n_total++; if (v !== 32'h0) $display("FAIL unmapped_data got=%h exp=0", v); else n_pass++;
    n_total++; if (c !== 1) $display("FAIL unmapped_latency got=%0d exp=1", c); else n_pass++;
    idle(1);
    n_total++; if (bus.ready_o !== 1'b0) $display("FAIL ready_pulse_width got=%b exp=0", bus.ready_o); else n_pass++;
    wr(8'h20, 32'hFFFF_FFFF, g, c);
    rd(A_STS, v, c);
    n_total++; if (v !== 32'h8) $display("FAIL unmapped_err_kept got=%h exp=%h", v, 32'h8); else n_pass++;
    wr(A_CTRL, 32'h2, g, c);
    rd(A_STS, v, c);
    n_total++; if (v !== 32'h0) $display("FAIL clear_err got=%h exp=0", v); else n_pass++;
  endtask

  task automatic test_add();
    logic [31:0] v; int c; logic g; logic ok;
    ok = 1'b1;
    wr(A_CTRL, 32'h0, g, c);          ok &= g;
    wr(A_OPA, 32'h3FC0_0000, g, c);   ok &= g;
    wr(A_OPB, 32'h4010_0000, g, c);   ok &= g;
    n_total++; if (ok !== 1'b1) $display("FAIL add_writes got=%b exp=1", ok); else n_pass++;
    // STATUS sampled CORE_LAT+1 cycles after accept: still in flight
    idle(CORE_LAT);
    rd(A_STS, v, c);
    n_total++; if (v !== 32'h0001_0004) $display("FAIL add_status_busy got=%h exp=%h", v, 32'h0001_0004); else n_pass++;
    rd(A_STS, v, c);
    n_total++; if (v !== 32'h0000_0101) $display("FAIL add_status_ready got=%h exp=%h", v, 32'h0000_0101); else n_pass++;
    rd(A_RES, v, c);
    n_total++; if (v !== 32'h4070_0000) $display("FAIL add_result got=%h exp=%h", v, 32'h4070_0000); else n_pass++;
    rd(A_STS, v, c);
    n_total++; if (v !== 32'h0) $display("FAIL add_status_after got=%h exp=0", v); else n_pass++;
  endtask

  task automatic test_sub();
    logic [31:0] v; int c; logic g; logic ok;
    ok = 1'b1;
    wr(A_CTRL, 32'h1, g, c);          ok &= g;
    rd(A_CTRL, v, c);
    n_total++; if (v !== 32'h1) $display("FAIL sub_mode_read got=%h exp=1", v); else n_pass++;
    wr(A_OPA, 32'h3FC0_0000, g, c);   ok &= g;
    wr(A_OPB, 32'h4010_0000, g, c);   ok &= g;
    n_total++; if (ok !== 1'b1) $display("FAIL sub_writes got=%b exp=1", ok); else n_pass++;
    // STATUS sampled exactly CORE_LAT+2 cycles after accept: nonempty
    idle(CORE_LAT + 1);
    rd(A_STS, v, c);
    n_total++; if (v !== 32'h0000_0101) $display("FAIL sub_nonempty_latency got=%h exp=%h", v, 32'h0000_0101); else n_pass++;
    rd(A_RES, v, c);
    n_total++; if (v !== 32'hBF40_0000) $display("FAIL sub_result got=%h exp=%h", v, 32'hBF40_0000); else n_pass++;
    wr(A_CTRL, 32'h0, g, c);
  endtask

  task automatic test_credit();
    logic [31:0] v; int c; logic g; logic ok;
    logic [31:0] opb [5];
    logic [31:0] exp_r [5];
    opb   = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
    exp_r = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
    ok = 1'b1;
    wr(A_OPA, 32'h3F80_0000, g, c); ok &= g;
    for (int i = 0; i < 4; i++) begin
      wr(A_OPB, opb[i], g, c); ok &= g;
    end
    n_total++; if (ok !== 1'b1) $display("FAIL credit_first4 got=%b exp=1", ok); else n_pass++;
    xfer(1'b1, A_OPB, opb[4], 30, v, g, c);
    n_total++; if (g !== 1'b0) $display("FAIL credit_stall got_ready=%b exp=0", g); else n_pass++;
    idle(1);
    rd(A_STS, v, c);
    n_total++; if (v !== 32'h0000_0403) $display("FAIL credit_full_status got=%h exp=%h", v, 32'h0000_0403); else n_pass++;
    rd(A_RES, v, c);
    n_total++; if (v !== exp_r[0]) $display("FAIL credit_res0 got=%h exp=%h", v, exp_r[0]); else n_pass++;
    wr(A_OPB, opb[4], g, c);
    n_total++; if (g !== 1'b1) $display("FAIL credit_5th_after_pop got=%b exp=1", g); else n_pass++;
    for (int i = 1; i < 5; i++) begin
      rd(A_RES, v, c);
      n_total++; if (v !== exp_r[i]) $display("FAIL credit_res%0d got=%h exp=%h", i, v, exp_r[i]); else n_pass++;
    end
  endtask

  task automatic test_blocking_read();
    logic [31:0] v; int c; logic g;
    wr(A_OPB, 32'h4000_0000, g, c);
    rd(A_RES, v, c);
    n_total++; if (v !== 32'h4040_0000) $display("FAIL block_read_data got=%h exp=%h", v, 32'h4040_0000); else n_pass++;
    n_total++; if (c !== CORE_LAT + 2) $display("FAIL block_read_cycles got=%0d exp=%0d", c, CORE_LAT + 2); else n_pass++;
    rd(A_RES, v, c);
    n_total++; if (v !== 32'h0) $display("FAIL empty_read_data got=%h exp=0", v); else n_pass++;
    rd(A_STS, v, c);
    n_total++; if (v !== 32'h8) $display("FAIL empty_read_err got=%h exp=%h", v, 32'h8); else n_pass++;
  endtask

  task automatic test_clear();
    logic [31:0] v; int c; logic g; logic ok;
    ok = 1'b1;
    wr(A_CTRL, 32'h2, g, c);         ok &= g;
    wr(A_OPA, 32'h3F80_0000, g, c);  ok &= g;
    for (int i = 0; i < 3; i++) begin
      wr(A_OPB, 32'h3F80_0000, g, c); ok &= g;
    end
    n_total++; if (ok !== 1'b1) $display("FAIL clear_setup got=%b exp=1", ok); else n_pass++;
    wr(A_CTRL, 32'h2, g, c);
    n_total++; if (g !== 1'b1) $display("FAIL clear_ready got=%b exp=1", g); else n_pass++;
    n_total++; if (c !== CORE_LAT + 2) $display("FAIL clear_cycles got=%0d exp=%0d", c, CORE_LAT + 2); else n_pass++;
    rd(A_STS, v, c);
    n_total++; if (v !== 32'h0) $display("FAIL clear_status got=%h exp=0", v); else n_pass++;
    wr(A_OPB, 32'h3F80_0000, g, c);
    rd(A_STS, v, c);
    n_total++; if (v !== 32'h8) $display("FAIL clear_drops_a got=%h exp=%h", v, 32'h8); else n_pass++;
    wr(A_CTRL, 32'h2, g, c);
  endtask

  task automatic test_reset_midflight();
    logic [31:0] v; int c; logic g;
    wr(A_OPA, 32'h3F80_0000, g, c);
    for (int i = 0; i < 3; i++) wr(A_OPB, 32'h3F80_0000, g, c);
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_total++; if (bus.ready_o !== 1'b0) $display("FAIL rst_mid_ready got=%b exp=0", bus.ready_o); else n_pass++;
    n_total++; if (bus.data_o !== 32'h0) $display("FAIL rst_mid_data got=%h exp=0", bus.data_o); else n_pass++;
    idle(20);
    rd(A_STS, v, c);
    n_total++; if (v !== 32'h0) $display("FAIL rst_mid_status got=%h exp=0", v); else n_pass++;
    rd(A_RES, v, c);
    n_total++; if (v !== 32'h0) $display("FAIL rst_mid_no_result got=%h exp=0", v); else n_pass++;
    rd(A_CTRL, v, c);
    n_total++; if (v !== 32'h0) $display("FAIL rst_mid_mode got=%h exp=0", v); else n_pass++;
  endtask

  initial begin
    bus.en_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_err_unmapped();
    test_add();
    test_sub();
    test_credit();
    test_blocking_read();
    test_clear();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
